// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit buffer and frame scheduler feeding the UART TX path.
// Stores 9-bit host words in a DEPTH-entry circular FIFO. It launches one word per
// frame by pulsing tx_enable/tx_load, and holds tx_data until the next launch.
// Optional feature macro: UART_TX_FIFO_OVF_EN adds the sticky overflow flag
// and the ovf_clr input. Without the macro, overflow is tied low.
module uart_tx_fifo #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned AW           = 3,
    parameter int unsigned FRAME_CYCLES = 14
) (
    input  logic          txclk,
    input  logic          reset_n,
    input  logic          wr_valid,
    input  logic [8:0]    wr_data,
    output logic          wr_ready,
    input  logic          flush,
`ifdef UART_TX_FIFO_OVF_EN
    input  logic          ovf_clr,
`endif
    output logic          tx_enable,
    output logic          tx_load,
    output logic [8:0]    tx_data,
    output logic [AW:0]   fifo_count,
    output logic          busy,
    output logic          overflow
);

    localparam int unsigned CW = $clog2(FRAME_CYCLES);
    localparam int unsigned DW = 9;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tx_en_q, tx_en_d;
    logic [DW-1:0] tx_data_q, tx_data_d;
    logic          push_c;
    logic          pop_c;
    logic          full_c;
    logic          empty_c;

    assign full_c     = (count_q == (AW+1)'(DEPTH));
    assign empty_c    = (count_q == '0);
    assign wr_ready   = !full_c;
    assign fifo_count = count_q;
    assign busy       = (state_q != ST_IDLE);
    assign tx_enable  = tx_en_q;
    assign tx_load    = tx_en_q;
    assign tx_data    = tx_data_q;

    // Write acceptance: flush discards any write in the same cycle.
    assign push_c = wr_valid && !full_c && !flush;

    // Launch scheduler: pop/pulse decisions and frame down-counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        pop_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!flush && !empty_c) begin
                    pop_c     = 1'b1;
                    tx_en_d   = 1'b1;
                    tx_data_d = mem_q[rd_ptr_q];
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                cnt_d   = CW'(FRAME_CYCLES - 2);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!flush && !empty_c) begin
                    pop_c     = 1'b1;
                    tx_en_d   = 1'b1;
                    tx_data_d = mem_q[rd_ptr_q];
                    state_d   = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO pointer and occupancy update; flush clears everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push_c && !pop_c) begin
                count_d = count_q + (AW+1)'(1);
            end else if (pop_c && !push_c) begin
                count_d = count_q - (AW+1)'(1);
            end
        end
    end

    // Storage array; contents need no reset since the count gates every read.
    always_ff @(posedge txclk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // State, pointer and output registers.
    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky overflow: a dropped write sets it, and set wins over clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (wr_valid && full_c && !flush) begin
            ovf_d = 1'b1;
        end
    end

    // Overflow flag register.
    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. The stimulus queues the expected launched
// words, and a negedge monitor pops and compares them on every tx_enable pulse.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned FRAME = 14;

    logic          txclk;
    logic          reset_n;
    logic          wr_valid;
    logic [8:0]    wr_data;
    logic          wr_ready;
    logic          flush;
`ifdef UART_TX_FIFO_OVF_EN
    logic          ovf_clr;
`endif
    logic          tx_enable;
    logic          tx_load;
    logic [8:0]    tx_data;
    logic [AW:0]   fifo_count;
    logic          busy;
    logic          overflow;

    uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW), .FRAME_CYCLES(FRAME)) dut (
        .txclk      (txclk),
        .reset_n    (reset_n),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .flush      (flush),
`ifdef UART_TX_FIFO_OVF_EN
        .ovf_clr    (ovf_clr),
`endif
        .tx_enable  (tx_enable),
        .tx_load    (tx_load),
        .tx_data    (tx_data),
        .fifo_count (fifo_count),
        .busy       (busy),
        .overflow   (overflow)
    );

    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         cyc = 0;
    int         last_pulse = 0;
    bit         b2b = 0;
    logic       prev_en = 1'b0;
    logic [8:0] held = 9'h0;
    logic [8:0] exp_q [$];

    initial begin
        txclk = 1'b0;
        forever #5 txclk = ~txclk;
    end

    always @(posedge txclk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge txclk);
        #1;
    endtask

    task automatic wr(input logic [8:0] d, input bit accept);
        if (accept) exp_q.push_back(d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            tick();
            n++;
        end
        chk("drain_done", 32'(n < 400), 1);
    endtask

    // Monitor: launched word order, pulse width, spacing and tx_data hold.
    always @(negedge txclk) begin
        logic [8:0] e;
        if (!reset_n) begin
            held    = 9'h0;
            prev_en = 1'b0;
        end else begin
            if (tx_enable) begin
                chk("pulse_single_cycle", 32'(prev_en), 0);
                chk("tx_load_pulse", 32'(tx_load), 1);
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_launch: tx_data=%0h expected no launch (cycle %0d)", tx_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_data_word", 32'(tx_data), 32'(e));
                end
                if (b2b) chk("launch_spacing", 32'(cyc - last_pulse), FRAME);
                last_pulse = cyc;
                b2b        = (exp_q.size() != 0);
                held       = tx_data;
            end else begin
                chk("tx_data_hold", 32'(tx_data), 32'(held));
                chk("tx_load_low", 32'(tx_load), 0);
            end
            prev_en = tx_enable;
        end
    end

    initial begin
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 9'h0;
        flush    = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
        ovf_clr  = 1'b0;
`endif
        repeat (3) tick();

        // Reset values.
        chk("rst_tx_enable", 32'(tx_enable), 0);
        chk("rst_tx_load", 32'(tx_load), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_wr_ready", 32'(wr_ready), 1);
        chk("rst_count", 32'(fifo_count), 0);
        reset_n = 1'b1;
        tick();

        // Single word: launch two edges after the write, busy for one frame.
        wr(9'h1A5, 1);
        chk("single_count1", 32'(fifo_count), 1);
        chk("single_idle_busy", 32'(busy), 0);
        chk("single_no_pulse_yet", 32'(tx_enable), 0);
        tick();
        chk("single_pulse", 32'(tx_enable), 1);
        chk("single_data", 32'(tx_data), 32'h1A5);
        chk("single_busy", 32'(busy), 1);
        chk("single_count0", 32'(fifo_count), 0);
        repeat (FRAME - 1) tick();
        chk("single_busy_late", 32'(busy), 1);
        tick();
        chk("single_busy_fall", 32'(busy), 0);
        chk("single_data_held", 32'(tx_data), 32'h1A5);

        // Burst of five: count peaks at 4, launches back to back.
        for (int i = 0; i < 5; i++) wr(9'(9'h101 + i), 1);
        chk("burst_peak", 32'(fifo_count), 4);
        wait_drain();
        chk("burst_empty", 32'(fifo_count), 0);

        // Full: nine accepted, tenth dropped.
        for (int i = 0; i < 9; i++) wr(9'(9'h0C0 + i), 1);
        chk("full_count", 32'(fifo_count), 8);
        chk("full_not_ready", 32'(wr_ready), 0);
        wr(9'h0FF, 0);
        chk("full_drop_count", 32'(fifo_count), 8);
        chk("full_drop_not_ready", 32'(wr_ready), 0);
`ifdef UART_TX_FIFO_OVF_EN
        chk("ovf_set", 32'(overflow), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);
`else
        chk("ovf_tied_low", 32'(overflow), 0);
`endif
        wait_drain();
        chk("full_ready_again", 32'(wr_ready), 1);

        // Simultaneous push and pop at count 3, pointers wrapping past 7.
        for (int i = 0; i < 4; i++) wr(9'(9'h1E0 + i), 1);
        chk("simul_pre_count", 32'(fifo_count), 3);
        repeat (11) tick();
        wr(9'h1E4, 1);
        chk("simul_count", 32'(fifo_count), 3);
        chk("simul_pulse", 32'(tx_enable), 1);
        wait_drain();

        // Flush during WAIT: no further launches, current word held.
        for (int i = 0; i < 4; i++) wr(9'(9'h150 + i), 1);
        chk("flush_pre_count", 32'(fifo_count), 3);
        tick();
        exp_q.delete();
        b2b      = 0;
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 9'h1FF;
        tick();
        flush    = 1'b0;
        wr_valid = 1'b0;
        chk("flush_count", 32'(fifo_count), 0);
        chk("flush_busy", 32'(busy), 1);
        chk("flush_data", 32'(tx_data), 32'h150);
        chk("flush_ready", 32'(wr_ready), 1);
        repeat (FRAME + 4) tick();
        chk("flush_idle", 32'(busy), 0);
        chk("flush_count_late", 32'(fifo_count), 0);
        chk("flush_data_late", 32'(tx_data), 32'h150);

        // Async reset mid-WAIT for half a cycle.
        wr(9'h133, 1);
        wr(9'h134, 1);
        repeat (4) tick();
        exp_q.delete();
        b2b     = 0;
        reset_n = 1'b0;
        #2;
        chk("arst_tx_enable", 32'(tx_enable), 0);
        chk("arst_tx_load", 32'(tx_load), 0);
        chk("arst_tx_data", 32'(tx_data), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_count", 32'(fifo_count), 0);
        chk("arst_wr_ready", 32'(wr_ready), 1);
        chk("arst_overflow", 32'(overflow), 0);
        #3;
        reset_n = 1'b1;
        repeat (2 * FRAME) tick();
        chk("arst_stays_idle", 32'(busy), 0);
        chk("arst_stays_empty", 32'(fifo_count), 0);
        wr(9'h0A5, 1);
        wait_drain();
        chk("arst_new_word", 32'(tx_data), 32'h0A5);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
